// File: rtl/aes_axil_pkg.sv
// Shared constants for the AES AXI4-Lite register bank: response codes,
// CTRL bit positions, write-joiner states and a clog2 helper.
package aes_axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int CTRL_START_BIT  = 0;
  localparam int CTRL_IRQ_EN_BIT = 1;
  localparam int CTRL_DONE_BIT   = 2;

  // WJ_INIT holds every ready low for the first cycle after reset release.
  typedef enum logic [2:0] {
    WJ_INIT,
    WJ_IDLE,
    WJ_HAVE_AW,
    WJ_HAVE_W,
    WJ_RESP
  } wr_state_e;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_axil_regbank_if.sv
// AXI4-Lite slave bus for the register bank.
// Every channel uses valid/ready: a transfer happens on the rising edge where
// both are high; a raised valid keeps its payload stable until that edge.
interface aes_axil_regbank_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/aes_axil_wr_join.sv
// Joins the AW and W channels in either order and issues the B response.
// wr_en fires on the edge where the second of the two arrives, so the
// register file updates and BVALID rises on the same edge.
module aes_axil_wr_join
  import aes_axil_pkg::*;
#(
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 32,
  parameter int WORD_LSB = 2,
  parameter int RO_BASE  = 12
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [ADDR_W-1:0]            awaddr,
  input  logic                         awvalid,
  output logic                         awready,
  input  logic [DATA_W-1:0]            wdata,
  input  logic [DATA_W/8-1:0]          wstrb,
  input  logic                         wvalid,
  output logic                         wready,
  output logic [1:0]                   bresp,
  output logic                         bvalid,
  input  logic                         bready,
  output logic                         wr_en,
  output logic [ADDR_W-WORD_LSB-1:0]   wr_idx,
  output logic [DATA_W-1:0]            wr_data,
  output logic [DATA_W/8-1:0]          wr_strb,
  output wr_state_e                    state_dbg
);
  localparam int IDX_W = ADDR_W - WORD_LSB;

  wr_state_e           state_q, state_d;
  logic [IDX_W-1:0]    aw_idx_q;
  logic [DATA_W-1:0]   w_data_q;
  logic [DATA_W/8-1:0] w_strb_q;
  logic                unused_addr_lsb;

  assign unused_addr_lsb = ^awaddr[WORD_LSB-1:0];
  assign state_dbg = state_q;
  assign bvalid    = (state_q == WJ_RESP);

  // Commit uses whichever half was latched earlier plus the half arriving now
  assign wr_idx  = (state_q == WJ_HAVE_AW) ? aw_idx_q : awaddr[ADDR_W-1:WORD_LSB];
  assign wr_data = (state_q == WJ_HAVE_W) ? w_data_q : wdata;
  assign wr_strb = (state_q == WJ_HAVE_W) ? w_strb_q : wstrb;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= WJ_INIT;
    else        state_q <= state_d;
  end

  // Next state, channel readies and commit strobe
  always_comb begin
    state_d = state_q;
    awready = 1'b0;
    wready  = 1'b0;
    wr_en   = 1'b0;
    case (state_q)
      WJ_INIT: state_d = WJ_IDLE;
      WJ_IDLE: begin
        awready = 1'b1;
        wready  = 1'b1;
        if (awvalid && wvalid) begin
          wr_en   = 1'b1;
          state_d = WJ_RESP;
        end else if (awvalid) begin
          state_d = WJ_HAVE_AW;
        end else if (wvalid) begin
          state_d = WJ_HAVE_W;
        end
      end
      WJ_HAVE_AW: begin
        wready = 1'b1;
        if (wvalid) begin
          wr_en   = 1'b1;
          state_d = WJ_RESP;
        end
      end
      WJ_HAVE_W: begin
        awready = 1'b1;
        if (awvalid) begin
          wr_en   = 1'b1;
          state_d = WJ_RESP;
        end
      end
      WJ_RESP: if (bready) state_d = WJ_IDLE;
      default: state_d = WJ_IDLE;
    endcase
  end

  // Early-half latches and response code (read-only targets are refused)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_idx_q <= '0;
      w_data_q <= '0;
      w_strb_q <= '0;
      bresp    <= RESP_OKAY;
    end else begin
      if (awvalid && awready) aw_idx_q <= awaddr[ADDR_W-1:WORD_LSB];
      if (wvalid && wready) begin
        w_data_q <= wdata;
        w_strb_q <= wstrb;
      end
      if (wr_en) bresp <= (wr_idx >= IDX_W'(RO_BASE)) ? RESP_SLVERR : RESP_OKAY;
    end
  end

endmodule

// File: rtl/aes_axil_regbank.sv
// AXI4-Lite register bank for the AES core: CTRL at word 0, RW words above
// it, and C_NUM_RO read-only words at the top of the map fed live from ro_in.
module aes_axil_regbank
  import aes_axil_pkg::*;
#(
  parameter int C_DATA_WIDTH = 32,
  parameter int C_NUM_REGS   = 16,
  parameter int C_NUM_RO     = 4
) (
  input  logic                                          ACLK,
  input  logic                                          ARESETN,
  aes_axil_regbank_if.slave                             s_axi,
  input  logic [C_NUM_RO*C_DATA_WIDTH-1:0]              ro_in,
  output logic [(C_NUM_REGS-C_NUM_RO-1)*C_DATA_WIDTH-1:0] rw_out,
  output logic                                          start_pulse,
  input  logic                                          done_in,
  output logic                                          irq
);
  localparam int STRB_W       = C_DATA_WIDTH / 8;
  localparam int WORD_LSB     = clog2(STRB_W);
  localparam int IDX_W        = clog2(C_NUM_REGS);
  localparam int C_ADDR_WIDTH = IDX_W + WORD_LSB;
  localparam int RO_BASE      = C_NUM_REGS - C_NUM_RO;

  logic [C_DATA_WIDTH-1:0] rw_q [1:RO_BASE-1];
  logic                    irq_en_q, done_q;
  logic                    wr_en, ctrl_wr;
  logic [IDX_W-1:0]        wr_idx, rd_idx;
  logic [C_DATA_WIDTH-1:0] wr_data, rd_word, rdata_q;
  logic [STRB_W-1:0]       wr_strb;
  logic                    rd_ready_q, rvalid_q;
  logic [1:0]              rresp_q;
  wr_state_e               wr_state;
  logic                    unused_bits;

  assign unused_bits = ^{s_axi.awprot, s_axi.arprot, s_axi.araddr[WORD_LSB-1:0], wr_state};

  aes_axil_wr_join #(
    .ADDR_W  (C_ADDR_WIDTH),
    .DATA_W  (C_DATA_WIDTH),
    .WORD_LSB(WORD_LSB),
    .RO_BASE (RO_BASE)
  ) u_wr_join (
    .clk      (ACLK),
    .rst_n    (ARESETN),
    .awaddr   (s_axi.awaddr),
    .awvalid  (s_axi.awvalid),
    .awready  (s_axi.awready),
    .wdata    (s_axi.wdata),
    .wstrb    (s_axi.wstrb),
    .wvalid   (s_axi.wvalid),
    .wready   (s_axi.wready),
    .bresp    (s_axi.bresp),
    .bvalid   (s_axi.bvalid),
    .bready   (s_axi.bready),
    .wr_en    (wr_en),
    .wr_idx   (wr_idx),
    .wr_data  (wr_data),
    .wr_strb  (wr_strb),
    .state_dbg(wr_state)
  );

  assign ctrl_wr = wr_en && (wr_idx == '0) && wr_strb[0];

  // RW register array with per-byte strobes
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 1; i < RO_BASE; i++) rw_q[i] <= '0;
    end else if (wr_en) begin
      for (int i = 1; i < RO_BASE; i++)
        if (wr_idx == IDX_W'(i))
          for (int b = 0; b < STRB_W; b++)
            if (wr_strb[b]) rw_q[i][8*b +: 8] <= wr_data[8*b +: 8];
    end
  end

  // CTRL: start strobe, IRQ_EN, sticky DONE where a completion beats a clear
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      irq_en_q    <= 1'b0;
      done_q      <= 1'b0;
      start_pulse <= 1'b0;
      irq         <= 1'b0;
    end else begin
      start_pulse <= ctrl_wr && wr_data[CTRL_START_BIT];
      if (ctrl_wr) irq_en_q <= wr_data[CTRL_IRQ_EN_BIT];
      if (done_in) done_q <= 1'b1;
      else if (ctrl_wr && wr_data[CTRL_DONE_BIT]) done_q <= 1'b0;
      irq <= done_q & irq_en_q;
    end
  end

  // Flatten the RW words onto rw_out, word 1 in the low slice
  always_comb begin
    rw_out = '0;
    for (int i = 1; i < RO_BASE; i++) rw_out[(i-1)*C_DATA_WIDTH +: C_DATA_WIDTH] = rw_q[i];
  end

  // Read mux over CTRL, RW words and live read-only inputs
  always_comb begin
    rd_idx  = s_axi.araddr[C_ADDR_WIDTH-1:WORD_LSB];
    rd_word = '0;
    if (rd_idx == '0) begin
      rd_word[CTRL_IRQ_EN_BIT] = irq_en_q;
      rd_word[CTRL_DONE_BIT]   = done_q;
    end
    for (int i = 1; i < RO_BASE; i++)
      if (rd_idx == IDX_W'(i)) rd_word = rw_q[i];
    for (int k = 0; k < C_NUM_RO; k++)
      if (rd_idx == IDX_W'(RO_BASE + k)) rd_word = ro_in[k*C_DATA_WIDTH +: C_DATA_WIDTH];
  end

  assign s_axi.arready = rd_ready_q && !rvalid_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;

  // Read channel: capture on AR handshake, hold until RREADY
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rd_ready_q <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
    end else begin
      rd_ready_q <= 1'b1;
      if (s_axi.arvalid && s_axi.arready) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_word;
        rresp_q  <= RESP_OKAY;
      end else if (rvalid_q && s_axi.rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

endmodule

// File: doc/aes_axil_regbank.md
AES_AXIL_REGBANK -- requirements
Module: aes_axil_regbank

Interface
REQ-001 Parameter C_DATA_WIDTH, default 32, AXI4-Lite data width; legal values 32 or 64.
REQ-002 Parameter C_NUM_REGS, default 16, total register count; power of two, 4..64.
REQ-003 Parameter C_NUM_RO, default 4, count of read-only registers at the top of the map; range 1..C_NUM_REGS-2.
REQ-004 Derived constant C_ADDR_WIDTH = clog2(C_NUM_REGS) + clog2(C_DATA_WIDTH/8).
REQ-005 ACLK  in  1  sole clock; all logic rising-edge.
REQ-006 ARESETN  in  1  asynchronous, active-low reset.
REQ-007 S_AXI_AWADDR/AWPROT/AWVALID/AWREADY  in/in/in/out  C_ADDR_WIDTH/3/1/1  write address channel.
REQ-008 S_AXI_WDATA/WSTRB/WVALID/WREADY  in/in/in/out  C_DATA_WIDTH/C_DATA_WIDTH/8/1/1  write data channel.
REQ-009 S_AXI_BRESP/BVALID/BREADY  out/out/in  2/1/1  write response channel.
REQ-010 S_AXI_ARADDR/ARPROT/ARVALID/ARREADY  in/in/in/out  C_ADDR_WIDTH/3/1/1  read address channel.
REQ-011 S_AXI_RDATA/RRESP/RVALID/RREADY  out/out/out/in  C_DATA_WIDTH/2/1/1  read data channel.
REQ-012 ro_in  in  C_NUM_RO*C_DATA_WIDTH  live values for read-only registers, sampled at read.
REQ-013 rw_out  out  (C_NUM_REGS-C_NUM_RO-1)*C_DATA_WIDTH  contents of registers 1..C_NUM_REGS-C_NUM_RO-1.
REQ-014 start_pulse  out  1  one-cycle core start strobe.
REQ-015 done_in  in  1  core completion pulse.
REQ-016 irq  out  1  level interrupt.

Function
REQ-017 Register 0 SHALL be CTRL: bit0 START (write-1 fires start_pulse, reads 0), bit1 IRQ_EN (RW), bit2 DONE (sticky, write-1-to-clear); other bits read 0.
REQ-018 Registers 1..C_NUM_REGS-C_NUM_RO-1 SHALL be RW with per-byte WSTRB masking; registers above SHALL return ro_in slices.
REQ-019 Word index SHALL be ADDR[C_ADDR_WIDTH-1:clog2(C_DATA_WIDTH/8)]; low address bits ignored.
REQ-020 AW and W SHALL be accepted independently in either order; AWREADY (WREADY) high while its address (data) is not yet latched and BVALID is low.
REQ-021 The register update SHALL occur in the cycle after both AW and W are latched; BVALID SHALL assert in that same cycle and hold until BREADY.
REQ-022 No new AW or W SHALL be accepted while BVALID is high; back-to-back writes sustain one per two cycles when BREADY held high.
REQ-023 ARREADY SHALL be high whenever RVALID is low; RDATA/RRESP SHALL register one cycle after AR handshake and hold stable until RREADY.
REQ-024 Write to a read-only register SHALL return BRESP=SLVERR (2'b10) and change nothing; all other writes and reads return OKAY.
REQ-025 Read and write completing the same cycle to the same register SHALL return the pre-write value.
REQ-026 start_pulse SHALL assert exactly one cycle, the cycle after the CTRL write with WSTRB[0]=1 and WDATA[0]=1.
REQ-027 done_in high SHALL set DONE; if done_in and a DONE W1C coincide, set wins.
REQ-028 irq SHALL equal registered DONE AND IRQ_EN (one-cycle latency from the update).
REQ-029 AWPROT/ARPROT SHALL be ignored.

Reset
REQ-030 ARESETN low SHALL immediately clear all RW registers, CTRL, DONE, start_pulse, irq, AWREADY, WREADY, ARREADY, BVALID, RVALID, RDATA, BRESP, RRESP, and any latched AW/W.
REQ-031 A transaction interrupted by reset SHALL be discarded; no response issued after release.
REQ-032 AWREADY, WREADY and ARREADY SHALL first assert one cycle after ARESETN deasserts.

Structure
REQ-033 Response encodings (OKAY, SLVERR), CTRL bit positions and the clog2 helper SHALL live in shared package aes_axil_pkg.
REQ-034 Write-channel joiner (AW/W latch plus B response) SHALL be sub-module aes_axil_wr_join; read path and register array stay in the top.

Verification
REQ-035 Write 0x00000001..0x00000004 to addresses 0x4,0x8,0xC,0x10, read back -> equal data, all RESP OKAY.
REQ-036 W issued three cycles before AW, WSTRB=4'b0101, data 0xAABBCCDD onto 0x11223344 at 0x4 -> readback 0x11BB33DD, single BVALID.
REQ-037 Write 0xDEADBEEF to highest address (RO) -> BRESP 2'b10, readback equals ro_in top slice.
REQ-038 Write CTRL=0x3 -> start_pulse high exactly one cycle; pulse done_in -> irq high next cycle; write CTRL=0x6 -> irq low, CTRL reads 0x2.
REQ-039 Hold BREADY/RREADY low ten cycles -> BVALID/RVALID and data stable, AWREADY/WREADY/ARREADY low until handshake.
REQ-040 Assert ARESETN low between AW and W latch -> no BVALID after release, register unchanged (reads 0).
